// File: rtl/uart_byte_tx_if.sv
// Byte handshake between a sync FIFO (master) and the UART byte transmitter (slave).
`timescale 1ns/1ps
interface uart_byte_tx_if;
    logic       i_en;
    logic [7:0] i_data;
    logic       i_rdy;

    modport master (output i_en, output i_data, input i_rdy);
    modport slave  (input i_en, input i_data, output i_rdy);
endinterface

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: 8N1 or 8E1 framing, one byte per frame, registered serial output.
`timescale 1ns/1ps
module uart_byte_tx #(
    parameter int unsigned CLK_DIV   = 32'd434,
    parameter bit          PARITY_EN = 1'b0
) (
    input  logic           clk,
    input  logic           rstn,
    uart_byte_tx_if.slave  tx_if,
    output logic           o_uart_tx,
    output logic           o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 32'd1);

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;
    logic [2:0]  bit_cnt_r;
    logic [2:0]  bit_cnt_next_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_next_s;
    logic        parity_r;
    logic        parity_next_s;
    logic        tx_r;
    logic        tx_next_s;
    logic        busy_r;
    logic        handshake_s;
    logic        bit_end_s;

    // Ready is a pure state decode so the FIFO never sees a combinational loop.
    assign tx_if.i_rdy = (state_r == ST_IDLE);
    assign handshake_s = (state_r == ST_IDLE) && tx_if.i_en;
    assign bit_end_s   = (cnt_r == DIV_LAST);
    assign o_uart_tx   = tx_r;
    assign o_busy      = busy_r;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: each bit period ends when the cycle counter reaches CLK_DIV-1.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) state_next_s = ST_START;
                else             state_next_s = ST_IDLE;
            end
            ST_START: begin
                if (bit_end_s) state_next_s = ST_DATA;
                else           state_next_s = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_cnt_r == 3'd7)) state_next_s = PARITY_EN ? ST_PARITY : ST_STOP;
                else                                  state_next_s = ST_DATA;
            end
            ST_PARITY: begin
                if (bit_end_s) state_next_s = ST_STOP;
                else           state_next_s = ST_PARITY;
            end
            ST_STOP: begin
                if (bit_end_s) state_next_s = ST_IDLE;
                else           state_next_s = ST_STOP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath and line value for the next cycle; tx follows the state being entered.
    always_comb begin
        cnt_next_s     = cnt_r;
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s   = shift_r;
        parity_next_s  = parity_r;
        tx_next_s      = 1'b1;

        if (state_r == ST_IDLE) begin
            cnt_next_s = 16'd0;
        end else if (bit_end_s) begin
            cnt_next_s = 16'd0;
        end else begin
            cnt_next_s = cnt_r + 16'd1;
        end

        if (handshake_s) begin
            shift_next_s   = tx_if.i_data;
            parity_next_s  = even_parity(tx_if.i_data);
            bit_cnt_next_s = 3'd0;
        end else if ((state_r == ST_DATA) && bit_end_s) begin
            shift_next_s   = {1'b0, shift_r[7:1]};
            bit_cnt_next_s = bit_cnt_r + 3'd1;
        end else begin
            shift_next_s   = shift_r;
            bit_cnt_next_s = bit_cnt_r;
        end

        case (state_next_s)
            ST_IDLE:   tx_next_s = 1'b1;
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
            ST_PARITY: tx_next_s = parity_next_s;
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // Datapath and output registers; reset forces the line high at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r     <= 16'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
            parity_r  <= 1'b0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            shift_r   <= shift_next_s;
            parity_r  <= parity_next_s;
            tx_r      <= tx_next_s;
            busy_r    <= (state_next_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench: three transmitter configurations checked cycle by cycle against a frame model.
`timescale 1ns/1ps
module tb_uart_byte_tx;

    logic       clk;
    logic       rstn;
    logic       en   [3];
    logic [7:0] data [3];
    logic       tx   [3];
    logic       rdy  [3];
    logic       busy [3];
    int         checks;
    int         failures;

    uart_byte_tx_if ifc0 ();
    uart_byte_tx_if ifc1 ();
    uart_byte_tx_if ifc2 ();

    assign ifc0.i_en = en[0];  assign ifc0.i_data = data[0];  assign rdy[0] = ifc0.i_rdy;
    assign ifc1.i_en = en[1];  assign ifc1.i_data = data[1];  assign rdy[1] = ifc1.i_rdy;
    assign ifc2.i_en = en[2];  assign ifc2.i_data = data[2];  assign rdy[2] = ifc2.i_rdy;

    uart_byte_tx #(.CLK_DIV(32'd4), .PARITY_EN(1'b0)) u0 (
        .clk(clk), .rstn(rstn), .tx_if(ifc0.slave), .o_uart_tx(tx[0]), .o_busy(busy[0]));
    uart_byte_tx #(.CLK_DIV(32'd4), .PARITY_EN(1'b1)) u1 (
        .clk(clk), .rstn(rstn), .tx_if(ifc1.slave), .o_uart_tx(tx[1]), .o_busy(busy[1]));
    uart_byte_tx #(.CLK_DIV(32'd3), .PARITY_EN(1'b0)) u2 (
        .clk(clk), .rstn(rstn), .tx_if(ifc2.slave), .o_uart_tx(tx[2]), .o_busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic bit par_of(int k);
        return (k == 1);
    endfunction

    // Expected line level for frame bit slot idx: start, 8 data LSB first, optional parity, stop.
    function automatic logic exp_bit(logic [7:0] b, bit par, int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if ((idx == 9) && par) return logic'($countones(b) % 2);
        return 1'b1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic handshake(int k, logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_wait", 32'(rdy[k]), 32'd1);
        en[k]   = 1'b1;
        data[k] = b;
        @(posedge clk);
    endtask

    // Called just after the handshake edge; checks every cycle of the frame and the idle cycle after it.
    task automatic check_frame(int k, logic [7:0] b, bit keep, logic [7:0] nxt, bit scramble);
        int         div;
        bit         par;
        int         nb;
        logic [7:0] rx;
        div = div_of(k);
        par = par_of(k);
        nb  = par ? 11 : 10;
        rx  = 8'd0;
        for (int idx = 0; idx < nb; idx++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                if (idx == 0 && c == 0) begin
                    if (keep) data[k] = nxt;
                    else      en[k]   = 1'b0;
                end else if (scramble) begin
                    data[k] = 8'($urandom);
                    en[k]   = 1'($urandom);
                end
                chk($sformatf("line k%0d b%02h slot%0d", k, b, idx), 32'(tx[k]), 32'(exp_bit(b, par, idx)));
                chk("busy_frame", 32'(busy[k]), 32'd1);
                chk("rdy_frame", 32'(rdy[k]), 32'd0);
                if (idx >= 1 && idx <= 8 && c == div / 2) rx[idx-1] = tx[k];
            end
        end
        @(negedge clk);
        if (!keep) en[k] = 1'b0;
        chk("idle_line", 32'(tx[k]), 32'd1);
        chk("idle_busy", 32'(busy[k]), 32'd0);
        chk("idle_rdy", 32'(rdy[k]), 32'd1);
        chk($sformatf("rx_byte k%0d", k), 32'(rx), 32'(b));
    endtask

    // Reset u0 ncyc cycles into a frame, try to push a byte during reset, then release.
    task automatic abort_frame(logic [7:0] b, int ncyc);
        handshake(0, b);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (n == 0) en[0] = 1'b0;
            chk("abort_pre", 32'(tx[0]), 32'(exp_bit(b, 1'b0, n / 4)));
        end
        rstn = 1'b0;
        #1;
        chk("abort_line", 32'(tx[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_rdy", 32'(rdy[0]), 32'd1);
        en[0]   = 1'b1;
        data[0] = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            chk("rst_line", 32'(tx[0]), 32'd1);
            chk("rst_busy", 32'(busy[0]), 32'd0);
            chk("rst_rdy", 32'(rdy[0]), 32'd1);
        end
        en[0] = 1'b0;
        rstn  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_line", 32'(tx[0]), 32'd1);
            chk("post_rst_busy", 32'(busy[0]), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] b;
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en[k]   = 1'b0;
            data[k] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_line", 32'(tx[k]), 32'd1);
            chk("reset_busy", 32'(busy[k]), 32'd0);
            chk("reset_rdy", 32'(rdy[k]), 32'd1);
        end
        rstn = 1'b1;

        // Idle with no valid byte.
        repeat (100) begin
            @(negedge clk);
            chk("idle100_line", 32'(tx[0]), 32'd1);
            chk("idle100_rdy", 32'(rdy[0]), 32'd1);
            chk("idle100_busy", 32'(busy[0]), 32'd0);
        end

        handshake(0, 8'h55);
        check_frame(0, 8'h55, 1'b0, 8'h00, 1'b0);

        handshake(1, 8'hA3);
        check_frame(1, 8'hA3, 1'b0, 8'h00, 1'b0);

        handshake(0, 8'h3C);
        check_frame(0, 8'h3C, 1'b0, 8'h00, 1'b1);

        // Back-to-back frames fed like a sync FIFO with i_en held high.
        q = '{8'h01, 8'h02, 8'h03};
        repeat (3) q.push_back(8'($urandom));
        handshake(2, q[0]);
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) @(posedge clk);
            b = (i + 1 < q.size()) ? q[i+1] : 8'h00;
            check_frame(2, q[i], (i + 1 < q.size()), b, 1'b0);
        end

        repeat (4) begin
            b = 8'($urandom);
            handshake(0, b);
            check_frame(0, b, 1'b0, 8'h00, 1'b1);
            b = 8'($urandom);
            handshake(1, b);
            check_frame(1, b, 1'b0, 8'h00, 1'b1);
        end

        abort_frame(8'h00, 18);
        abort_frame(8'hFF, 18);
        handshake(0, 8'h0F);
        check_frame(0, 8'h0F, 1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
